// File: rtl/axis_to_fifo_ser_pkg.sv
`default_nettype none
// ============================================================================
// axis_to_fifo_ser_pkg: shared widths, FSM encodings and lane-pack helpers.
// Rev 1.0
// ============================================================================
package axis_to_fifo_ser_pkg;

  localparam int unsigned C_LANE_W = 9;

  localparam logic [0:0] WR_HDR = 1'b0;
  localparam logic [0:0] WR_PKT = 1'b1;

  function automatic int unsigned packed_width(input int unsigned data_w);
    return (data_w / 8) * C_LANE_W;
  endfunction

  // Ceiling log2, never below 1 so index registers always have a bit.
  function automatic int unsigned log2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < v) r++;
    return (r == 0) ? 1 : r;
  endfunction

  function automatic logic [8:0] pack_lane(input logic [7:0] data_byte, input logic strb_bit);
    return {strb_bit, data_byte};
  endfunction

  localparam int unsigned C_DEF_PACK_W = packed_width(256);
  localparam int unsigned C_DEF_RATIO  = C_DEF_PACK_W / 72;

endpackage
`default_nettype wire

// File: rtl/axis_to_fifo_ser_fwft.sv
`default_nettype none
// ============================================================================
// axis_to_fifo_ser_fwft: synchronous FWFT FIFO; dout reads 0 while empty.
// Rev 1.0
// ============================================================================
module axis_to_fifo_ser_fwft #(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned DEPTH_BITS = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr,
  input  logic                  wr_en,
  input  logic [WIDTH-1:0]      din,
  input  logic                  rd_en,
  output logic [WIDTH-1:0]      dout,
  output logic                  empty,
  output logic [DEPTH_BITS:0]   count
);
  localparam int unsigned C_DEPTH = 1 << DEPTH_BITS;

  logic [WIDTH-1:0]      r_mem [C_DEPTH];
  logic [DEPTH_BITS-1:0] r_wr_ptr;
  logic [DEPTH_BITS-1:0] r_rd_ptr;
  logic [DEPTH_BITS:0]   r_count;
  logic                  w_full;
  logic                  w_wr;
  logic                  w_rd;

  // Full comes from the registered count, so a same-cycle read never frees a slot early.
  assign w_full = r_count[DEPTH_BITS];
  assign empty  = (r_count == '0);
  assign count  = r_count;
  assign w_wr   = wr_en && !w_full;
  assign w_rd   = rd_en && !empty;
  assign dout   = empty ? '0 : r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (clr) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_wr, w_rd})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/axis_to_fifo_ser_pack_serializer.sv
`default_nettype none
// ============================================================================
// axis_to_fifo_ser_pack_serializer: holds one packed word, emits it chunk 0 first.
// Rev 1.0
// ============================================================================
module axis_to_fifo_ser_pack_serializer
  import axis_to_fifo_ser_pkg::*;
#(
  parameter int unsigned WORD_W  = 288,
  parameter int unsigned CHUNK_W = 72
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clr,
  input  logic               load,
  input  logic [WORD_W-1:0]  word_in,
  input  logic               out_full,
  output logic               can_load,
  output logic               push,
  output logic [CHUNK_W-1:0] chunk
);
  localparam int unsigned        C_RATIO    = WORD_W / CHUNK_W;
  localparam int unsigned        C_IDX_W    = log2(C_RATIO);
  localparam logic [C_IDX_W-1:0] C_LAST_IDX = C_IDX_W'(C_RATIO - 1);

  logic               r_valid;
  logic [WORD_W-1:0]  r_word;
  logic [C_IDX_W-1:0] r_idx;
  logic               w_last;

  assign w_last   = (r_idx == C_LAST_IDX);
  assign push     = r_valid && !out_full;
  // Reloading on the final push keeps back-to-back words bubble-free.
  assign can_load = !r_valid || (push && w_last);
  assign chunk    = r_word[CHUNK_W*r_idx +: CHUNK_W];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_word  <= '0;
      r_idx   <= '0;
    end else if (clr) begin
      r_valid <= 1'b0;
      r_word  <= '0;
      r_idx   <= '0;
    end else if (load) begin
      r_valid <= 1'b1;
      r_word  <= word_in;
      r_idx   <= '0;
    end else if (push) begin
      r_valid <= !w_last;
      r_idx   <= w_last ? '0 : r_idx + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/axis_to_fifo_ser.sv
`default_nettype none
// ============================================================================
// axis_to_fifo_ser: AXIS beats packed 9 bits/lane, serialised into a FWFT FIFO.
// Define AXIS_TO_FIFO_HDR_EN to precede each packet with a tuser header word.
// Rev 1.0
// ============================================================================
module axis_to_fifo_ser
  import axis_to_fifo_ser_pkg::*;
#(
  parameter int unsigned C_S_AXIS_DATA_WIDTH  = 256,
  parameter int unsigned C_S_AXIS_TUSER_WIDTH = 128,
  parameter int unsigned FIFO_DATA_WIDTH      = 72,
  parameter int unsigned FIFO_DEPTH_BITS      = 4,
  parameter int unsigned IN_DEPTH_BITS        = 2
) (
  input  logic                              axi_aclk,
  input  logic                              axi_aresetn,
  input  logic [C_S_AXIS_DATA_WIDTH-1:0]    s_axis_tdata,
  input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  s_axis_tstrb,
  input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser,
  input  logic                              s_axis_tvalid,
  output logic                              s_axis_tready,
  input  logic                              s_axis_tlast,
  input  logic                              fifo_rd_en,
  output logic [FIFO_DATA_WIDTH-1:0]        fifo_dout,
  output logic                              fifo_empty,
  output logic [FIFO_DEPTH_BITS:0]          fifo_count,
  input  logic                              sw_rst
);
  localparam int unsigned C_D      = C_S_AXIS_DATA_WIDTH;
  localparam int unsigned C_U      = C_S_AXIS_TUSER_WIDTH;
  localparam int unsigned C_LANES  = C_D / 8;
  localparam int unsigned C_PACK_W = packed_width(C_D);
  localparam logic [IN_DEPTH_BITS:0] C_IN_NF = (IN_DEPTH_BITS + 1)'((1 << IN_DEPTH_BITS) - 1);
`ifdef AXIS_TO_FIFO_HDR_EN
  localparam int unsigned C_IN_W   = C_D + C_LANES + C_U + 1;
`else
  localparam int unsigned C_IN_W   = C_D + C_LANES;
`endif

  logic [C_IN_W-1:0]        w_in_din;
  logic [C_IN_W-1:0]        w_in_dout;
  logic                     w_in_empty;
  logic [IN_DEPTH_BITS:0]   w_in_count;
  logic [C_D-1:0]           w_head_data;
  logic [C_LANES-1:0]       w_head_strb;
  logic [C_PACK_W-1:0]      w_beat_word;
  logic [C_PACK_W-1:0]      w_word;
  logic                     w_load;
  logic                     w_pop;
  logic                     w_can_load;
  logic                     w_push;
  logic [FIFO_DATA_WIDTH-1:0] w_chunk;

  assign s_axis_tready = axi_aresetn && !sw_rst && (w_in_count < C_IN_NF);
  assign w_head_data   = w_in_dout[C_D-1:0];
  assign w_head_strb   = w_in_dout[C_D +: C_LANES];

  axis_to_fifo_ser_fwft #(
    .WIDTH      (C_IN_W),
    .DEPTH_BITS (IN_DEPTH_BITS)
  ) u_in_buf (
    .clk   (axi_aclk),
    .rst_n (axi_aresetn),
    .clr   (sw_rst),
    .wr_en (s_axis_tvalid && s_axis_tready),
    .din   (w_in_din),
    .rd_en (w_pop),
    .dout  (w_in_dout),
    .empty (w_in_empty),
    .count (w_in_count)
  );

  for (genvar i = 0; i < C_LANES; i++) begin : g_lane
    assign w_beat_word[9*i +: 9] = pack_lane(w_head_data[8*i +: 8], w_head_strb[i]);
  end

`ifdef AXIS_TO_FIFO_HDR_EN
  logic [C_U-1:0]      w_head_user;
  logic                w_head_last;
  logic [C_D-1:0]      w_user_ext;
  logic [C_PACK_W-1:0] w_hdr_word;
  logic [0:0]          r_state;

  assign w_in_din    = {s_axis_tlast, s_axis_tuser, s_axis_tstrb, s_axis_tdata};
  assign w_head_user = w_in_dout[C_D + C_LANES +: C_U];
  assign w_head_last = w_in_dout[C_IN_W-1];
  assign w_user_ext  = C_D'(w_head_user);

  for (genvar i = 0; i < C_LANES; i++) begin : g_hdr_lane
    assign w_hdr_word[9*i +: 9] = pack_lane(w_user_ext[8*i +: 8], 1'b1);
  end

  // The header is built from the first beat's tuser while that beat stays queued.
  always_comb begin
    w_load = 1'b0;
    w_pop  = 1'b0;
    w_word = w_beat_word;
    if (!w_in_empty && w_can_load) begin
      w_load = 1'b1;
      if (r_state == WR_HDR) w_word = w_hdr_word;
      else                   w_pop  = 1'b1;
    end
  end

  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      r_state <= WR_HDR;
    end else if (sw_rst) begin
      r_state <= WR_HDR;
    end else if (w_load) begin
      if (r_state == WR_HDR)  r_state <= WR_PKT;
      else if (w_head_last)   r_state <= WR_HDR;
    end
  end
`else
  logic w_unused;

  assign w_in_din = {s_axis_tstrb, s_axis_tdata};
  assign w_unused = ^{s_axis_tuser, s_axis_tlast};
  assign w_load   = !w_in_empty && w_can_load;
  assign w_pop    = w_load;
  assign w_word   = w_beat_word;
`endif

  axis_to_fifo_ser_pack_serializer #(
    .WORD_W  (C_PACK_W),
    .CHUNK_W (FIFO_DATA_WIDTH)
  ) u_ser (
    .clk      (axi_aclk),
    .rst_n    (axi_aresetn),
    .clr      (sw_rst),
    .load     (w_load),
    .word_in  (w_word),
    .out_full (fifo_count[FIFO_DEPTH_BITS]),
    .can_load (w_can_load),
    .push     (w_push),
    .chunk    (w_chunk)
  );

  axis_to_fifo_ser_fwft #(
    .WIDTH      (FIFO_DATA_WIDTH),
    .DEPTH_BITS (FIFO_DEPTH_BITS)
  ) u_out_fifo (
    .clk   (axi_aclk),
    .rst_n (axi_aresetn),
    .clr   (sw_rst),
    .wr_en (w_push),
    .din   (w_chunk),
    .rd_en (fifo_rd_en),
    .dout  (fifo_dout),
    .empty (fifo_empty),
    .count (fifo_count)
  );

endmodule
`default_nettype wire

// File: tb/tb_axis_to_fifo_ser.sv
`default_nettype none
// ============================================================================
// tb_axis_to_fifo_ser: scoreboard bench for axis_to_fifo_ser at default sizes.
// Rev 1.0
// ============================================================================
module tb_axis_to_fifo_ser;

`ifdef AXIS_TO_FIFO_HDR_EN
  localparam int C_HC   = 4;
  localparam int C_NPKT = 3;
`else
  localparam int C_HC   = 0;
  localparam int C_NPKT = 4;
`endif

  logic         axi_aclk = 1'b0;
  logic         axi_aresetn = 1'b0;
  logic [255:0] s_axis_tdata = '0;
  logic [31:0]  s_axis_tstrb = '0;
  logic [127:0] s_axis_tuser = '0;
  logic         s_axis_tvalid = 1'b0;
  logic         s_axis_tready;
  logic         s_axis_tlast = 1'b0;
  logic         fifo_rd_en = 1'b0;
  logic [71:0]  fifo_dout;
  logic         fifo_empty;
  logic [4:0]   fifo_count;
  logic         sw_rst = 1'b0;

  logic [71:0] sb[$];
  logic [71:0] rx[$];
  int n_cmp = 0;
  int n_err = 0;

  axis_to_fifo_ser dut (
    .axi_aclk      (axi_aclk),
    .axi_aresetn   (axi_aresetn),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tstrb  (s_axis_tstrb),
    .s_axis_tuser  (s_axis_tuser),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .s_axis_tlast  (s_axis_tlast),
    .fifo_rd_en    (fifo_rd_en),
    .fifo_dout     (fifo_dout),
    .fifo_empty    (fifo_empty),
    .fifo_count    (fifo_count),
    .sw_rst        (sw_rst)
  );

  always #5 axi_aclk = ~axi_aclk;

  task automatic chk(input string tag, input logic [71:0] got, input logic [71:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [287:0] pack(input logic [255:0] d, input logic [31:0] s);
    logic [287:0] w;
    for (int i = 0; i < 32; i++) w[9*i +: 9] = {s[i], d[8*i +: 8]};
    return w;
  endfunction

  function automatic logic [255:0] rand_data();
    logic [255:0] d;
    for (int i = 0; i < 8; i++) d[32*i +: 32] = $urandom;
    return d;
  endfunction

  task automatic push_word(input logic [287:0] w);
    for (int k = 0; k < 4; k++) sb.push_back(w[72*k +: 72]);
  endtask

  // Called at a negedge; returns at the negedge following the accepting edge.
  task automatic send_beat(input logic [255:0] d, input logic [31:0] s,
                           input logic [127:0] u, input logic last, input logic first);
    int t;
`ifdef AXIS_TO_FIFO_HDR_EN
    if (first) push_word(pack({128'd0, u}, 32'hFFFF_FFFF));
`else
    if (first) t = 0;
`endif
    push_word(pack(d, s));
    s_axis_tdata  = d;
    s_axis_tstrb  = s;
    s_axis_tuser  = u;
    s_axis_tlast  = last;
    s_axis_tvalid = 1'b1;
    t = 0;
    while (!s_axis_tready && t < 200) begin
      @(negedge axi_aclk);
      t++;
    end
    if (!s_axis_tready) begin
      chk("tready_timeout", 72'd0, 72'd1);
      s_axis_tvalid = 1'b0;
      return;
    end
    @(posedge axi_aclk);
    @(negedge axi_aclk);
    s_axis_tvalid = 1'b0;
  endtask

  // Called at a negedge; pops n chunks, reading continuously when data is ready.
  task automatic drain(input int n);
    int t;
    logic [71:0] e;
    for (int i = 0; i < n; i++) begin
      t = 0;
      while (fifo_empty && t < 200) begin
        @(negedge axi_aclk);
        t++;
      end
      if (fifo_empty) begin
        chk("drain_timeout", 72'd0, 72'd1);
        return;
      end
      if (sb.size() == 0) begin
        chk("sb_underflow", 72'd0, 72'd1);
        return;
      end
      e = sb.pop_front();
      rx.push_back(fifo_dout);
      chk("chunk", fifo_dout, e);
      fifo_rd_en = 1'b1;
      @(negedge axi_aclk);
      fifo_rd_en = 1'b0;
    end
  endtask

  initial begin
    logic [255:0] d;
    repeat (3) @(negedge axi_aclk);
    chk("rst_tready", 72'(s_axis_tready), 72'd0);
    chk("rst_empty",  72'(fifo_empty),    72'd1);
    chk("rst_count",  72'(fifo_count),    72'd0);
    chk("rst_dout",   fifo_dout,          72'd0);
    axi_aresetn = 1'b1;
    @(negedge axi_aclk);
    chk("tready_up", 72'(s_axis_tready), 72'd1);

    // One-beat packet, byte i = i, with latency check.
    for (int i = 0; i < 32; i++) d[8*i +: 8] = 8'(i);
    rx.delete();
    send_beat(d, 32'hFFFF_FFFF, 128'hAB, 1'b1, 1'b1);
    @(negedge axi_aclk);
    chk("lat_n1_empty", 72'(fifo_empty), 72'd1);
    @(negedge axi_aclk);
    chk("lat_n2_empty", 72'(fifo_empty), 72'd0);
    drain(C_HC + 4);
`ifdef AXIS_TO_FIFO_HDR_EN
    chk("hdr_lane0", 72'(rx[0][8:0]),  72'h1AB);
    chk("hdr_lane1", 72'(rx[0][17:9]), 72'h100);
`endif
    chk("beat_lane0", 72'(rx[C_HC][8:0]),  72'h100);
    chk("beat_lane1", 72'(rx[C_HC][17:9]), 72'h101);

    // Partial strobe on the last beat.
    rx.delete();
    send_beat(rand_data(), 32'hFFFF_FFFF, 128'($urandom), 1'b0, 1'b1);
    d = rand_data();
    send_beat(d, 32'h0000_000F, 128'($urandom), 1'b1, 1'b0);
    drain(C_HC + 8);
    chk("strb_lane3", 72'(rx[C_HC+4][35]), 72'd1);
    chk("strb_lane4", 72'(rx[C_HC+4][44]), 72'd0);
    chk("data_lane4", 72'(rx[C_HC+4][43:36]), 72'(d[39:32]));
    chk("strb_lane31", 72'(rx[C_HC+7][71]), 72'd0);

    // Backpressure: fill with no reads, then drain everything.
    for (int p = 0; p < C_NPKT; p++) begin
      send_beat(rand_data(), 32'hFFFF_FFFF, 128'($urandom), 1'b0, 1'b1);
      send_beat(rand_data(), $urandom, 128'($urandom), 1'b1, 1'b0);
    end
    repeat (30) @(negedge axi_aclk);
    chk("bp_count",  72'(fifo_count),    72'd16);
    chk("bp_tready", 72'(s_axis_tready), 72'd0);
    drain(C_NPKT * (C_HC + 8));
    chk("bp_sb_left", 72'(sb.size()), 72'd0);
    repeat (3) @(negedge axi_aclk);
    chk("bp_empty", 72'(fifo_empty), 72'd1);

    // Software reset mid-packet.
    send_beat(rand_data(), 32'hFFFF_FFFF, 128'($urandom), 1'b0, 1'b1);
    send_beat(rand_data(), 32'hFFFF_FFFF, 128'($urandom), 1'b0, 1'b0);
    repeat (3) @(negedge axi_aclk);
    sw_rst = 1'b1;
    #1 chk("swrst_tready", 72'(s_axis_tready), 72'd0);
    @(negedge axi_aclk);
    sw_rst = 1'b0;
    chk("swrst_empty", 72'(fifo_empty), 72'd1);
    chk("swrst_count", 72'(fifo_count), 72'd0);
    sb.delete();
    send_beat(rand_data(), $urandom, 128'h5A5A, 1'b1, 1'b1);
    drain(C_HC + 4);

    // Asynchronous reset between edges.
    send_beat(rand_data(), 32'hFFFF_FFFF, 128'($urandom), 1'b0, 1'b1);
    @(negedge axi_aclk);
    #2 axi_aresetn = 1'b0;
    #1;
    chk("arst_tready", 72'(s_axis_tready), 72'd0);
    chk("arst_empty",  72'(fifo_empty),    72'd1);
    chk("arst_count",  72'(fifo_count),    72'd0);
    sb.delete();
    @(negedge axi_aclk);
    axi_aresetn = 1'b1;
    @(negedge axi_aclk);
    chk("arst_tready_up", 72'(s_axis_tready), 72'd1);
    send_beat(rand_data(), $urandom, 128'hC3, 1'b1, 1'b1);
    drain(C_HC + 4);
    chk("end_sb_left", 72'(sb.size()), 72'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
